mc_alu_sequencer: RTL and testbench

- Multi-cycle main control FSM. It is the issuing end of the ALU control interface.
- Decodes opcode/funct from the instruction register and steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives the 4-bit ALU control code, operand selects and datapath write enables, and consumes the ALU `zero` flag for branches.
- Sits between the IR and the multi-cycle datapath; replaces combinational main control when the CPU is built multi-cycle.

---
 rtl/mc_alu_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_mc_alu_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mc_alu_sequencer.sv
// Multi-cycle main control FSM: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB, drives ALU control, operand selects and
// datapath write enables, and counts retired instructions.
module mc_alu_sequencer #(
  parameter int          CNT_W   = 32,
  parameter logic [5:0]  HALT_OP = 6'h3F
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic [3:0]       alu_control,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             pc_write,
  output logic [1:0]       pc_source,
  output logic             ir_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             illegal,
  output logic             halted,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  state_t cur, nxt;
  logic   retire;

  // R-type funct to ALU code; unsupported functs never reach EXEC.
  function automatic logic [3:0] r_alu(input logic [5:0] f);
    case (f)
      6'h00:        r_alu = 4'b0010;
      6'h20, 6'h21: r_alu = 4'b0000;
      6'h22, 6'h23: r_alu = 4'b0001;
      6'h24:        r_alu = 4'b0100;
      6'h25:        r_alu = 4'b0011;
      6'h26:        r_alu = 4'b0111;
      6'h2A:        r_alu = 4'b0110;
      6'h2B:        r_alu = 4'b0101;
      default:      r_alu = 4'b0000;
    endcase
  endfunction

  function automatic logic r_legal(input logic [5:0] f);
    case (f)
      6'h00, 6'h20, 6'h21, 6'h22, 6'h23,
      6'h24, 6'h25, 6'h26, 6'h2A, 6'h2B: r_legal = 1'b1;
      default:                           r_legal = 1'b0;
    endcase
  endfunction

  // I-arithmetic opcode to ALU code.
  function automatic logic [3:0] i_alu(input logic [5:0] op);
    case (op)
      6'h08, 6'h09: i_alu = 4'b0000;
      6'h0C:        i_alu = 4'b0100;
      6'h0D:        i_alu = 4'b0011;
      6'h0E:        i_alu = 4'b0111;
      6'h0A:        i_alu = 4'b0110;
      6'h0B:        i_alu = 4'b0101;
      default:      i_alu = 4'b0000;
    endcase
  endfunction

  logic is_r, is_iar, is_lw, is_sw, is_beq, is_bne, is_j, is_halt, legal;

  assign is_r    = (opcode == 6'h00);
  assign is_iar  = (opcode >= 6'h08) && (opcode <= 6'h0E) && (opcode != 6'h0F);
  assign is_lw   = (opcode == 6'h23);
  assign is_sw   = (opcode == 6'h2B);
  assign is_beq  = (opcode == 6'h04);
  assign is_bne  = (opcode == 6'h05);
  assign is_j    = (opcode == 6'h02);
  assign is_halt = (opcode == HALT_OP);
  assign legal   = (is_r && r_legal(funct)) || is_iar || is_lw || is_sw ||
                   is_beq || is_bne;

  assign state = cur;

  // State register and retired-instruction counter; reset beats everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur     <= FETCH;
      retired <= '0;
    end else begin
      cur <= nxt;
      if (retire) retired <= retired + CNT_W'(1);
    end
  end

  // Next-state and control-output decode; reset forces all enables/selects low.
  always_comb begin
    nxt         = cur;
    retire      = 1'b0;
    alu_control = 4'b0000;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    pc_write    = 1'b0;
    pc_source   = 2'b00;
    ir_write    = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    illegal     = 1'b0;
    halted      = 1'b0;
    case (cur)
      FETCH: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        alu_src_b = 2'b01;
        nxt       = DECODE;
      end
      DECODE: begin
        // Branch target is precomputed into ALUOut here.
        alu_src_b = 2'b11;
        if (is_j) begin
          pc_write  = 1'b1;
          pc_source = 2'b10;
          retire    = 1'b1;
          nxt       = FETCH;
        end else if (is_halt) begin
          nxt = HALT;
        end else if (legal) begin
          nxt = EXEC;
        end else begin
          illegal = 1'b1;
          nxt     = FETCH;
        end
      end
      EXEC: begin
        nxt = FETCH;
        if (is_r) begin
          alu_src_a   = (funct == 6'h00) ? 2'b10 : 2'b01;
          alu_control = r_alu(funct);
          nxt         = WB;
        end else if (is_iar) begin
          alu_src_a   = 2'b01;
          alu_src_b   = 2'b10;
          alu_control = i_alu(opcode);
          nxt         = WB;
        end else if (is_lw || is_sw) begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
          nxt       = MEM;
        end else if (is_beq || is_bne) begin
          alu_src_a   = 2'b01;
          alu_control = 4'b0001;
          pc_source   = 2'b01;
          pc_write    = (is_beq && zero) || (is_bne && !zero);
          retire      = 1'b1;
        end
      end
      MEM: begin
        nxt = FETCH;
        if (is_lw) begin
          mem_read = 1'b1;
          nxt      = WB;
        end else if (is_sw) begin
          mem_write = 1'b1;
          retire    = 1'b1;
        end
      end
      WB: begin
        reg_write  = 1'b1;
        reg_dst    = is_r;
        mem_to_reg = is_lw;
        retire     = 1'b1;
        nxt        = FETCH;
      end
      HALT: begin
        halted = 1'b1;
        nxt    = HALT;
      end
      default: nxt = FETCH;
    endcase
    if (!rst_n) begin
      alu_control = 4'b0000;
      alu_src_a   = 2'b00;
      alu_src_b   = 2'b00;
      pc_write    = 1'b0;
      pc_source   = 2'b00;
      ir_write    = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      reg_write   = 1'b0;
      reg_dst     = 1'b0;
      mem_to_reg  = 1'b0;
      illegal     = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_alu_sequencer.sv
// Scoreboard bench for mc_alu_sequencer: stimulus pushes per-cycle
// expected control vectors (with care masks), a negedge monitor compares.
module tb_mc_alu_sequencer;

  typedef struct packed {
    logic [2:0]  st;
    logic [3:0]  alu;
    logic [1:0]  sa;
    logic [1:0]  sb;
    logic        pw;
    logic [1:0]  ps;
    logic        irw;
    logic        mr;
    logic        mw;
    logic        rw;
    logic        rd;
    logic        m2r;
    logic        ill;
    logic        hlt;
    logic [31:0] ret;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  opcode, funct;
  logic        zero;
  logic [3:0]  alu_control;
  logic [1:0]  alu_src_a, alu_src_b, pc_source;
  logic        pc_write, ir_write, mem_read, mem_write, reg_write;
  logic        reg_dst, mem_to_reg, illegal, halted;
  logic [2:0]  state;
  logic [31:0] retired;

  mc_alu_sequencer #(.CNT_W(32), .HALT_OP(6'h3F)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .alu_control(alu_control), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .pc_write(pc_write), .pc_source(pc_source), .ir_write(ir_write),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .illegal(illegal),
    .halted(halted), .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  exp_t act;
  assign act = {state, alu_control, alu_src_a, alu_src_b, pc_write, pc_source,
                ir_write, mem_read, mem_write, reg_write, reg_dst, mem_to_reg,
                illegal, halted, retired};

  exp_t  q_e[$];
  exp_t  q_m[$];
  string q_t[$];
  exp_t  e, m;
  string tag;
  int    n_cmp = 0;
  int    n_bad = 0;

  // Monitor: one expected vector per clock cycle, checked mid-cycle.
  always @(negedge clk) begin
    if (q_e.size() > 0) begin
      exp_t        xe, xm;
      string       xt;
      logic [53:0] va, ve, vm;
      xe = q_e.pop_front();
      xm = q_m.pop_front();
      xt = q_t.pop_front();
      va = act; ve = xe; vm = xm;
      n_cmp++;
      if (((va ^ ve) & vm) != '0) begin
        n_bad++;
        $display("FAIL %s: got %h required %h (care mask %h)", xt, va, ve, vm);
      end
    end
  end

  task automatic step();
    q_e.push_back(e);
    q_m.push_back(m);
    q_t.push_back(tag);
    @(posedge clk); #1;
  endtask

  task automatic set_in(input logic [5:0] op, input logic [5:0] fn, input logic z);
    opcode = op; funct = fn; zero = z;
  endtask

  task automatic t_fetch(input logic [31:0] ret);
    e = '0; m = '1;
    e.st = 3'd0; e.sb = 2'b01; e.pw = 1'b1; e.irw = 1'b1; e.mr = 1'b1; e.ret = ret;
    m.rd = 1'b0; m.m2r = 1'b0;
    step();
  endtask

  task automatic t_decode(input logic ill, input logic jmp, input logic [31:0] ret);
    e = '0; m = '1;
    e.st = 3'd1; e.sb = 2'b11; e.pw = jmp; e.ill = ill; e.ret = ret;
    if (jmp) e.ps = 2'b10; else m.ps = 2'b00;
    m.rd = 1'b0; m.m2r = 1'b0;
    step();
  endtask

  task automatic t_exec(input logic [3:0] alu, input logic [1:0] sa, input logic [1:0] sb,
                        input logic pw, input logic br, input logic [31:0] ret);
    e = '0; m = '1;
    e.st = 3'd2; e.alu = alu; e.sa = sa; e.sb = sb; e.pw = pw; e.ret = ret;
    if (br) e.ps = 2'b01; else m.ps = 2'b00;
    m.rd = 1'b0; m.m2r = 1'b0;
    step();
  endtask

  task automatic t_mem(input logic mr, input logic mw, input logic [31:0] ret);
    e = '0; m = '1;
    e.st = 3'd3; e.mr = mr; e.mw = mw; e.ret = ret;
    m.alu = '0; m.sa = '0; m.sb = '0; m.ps = '0; m.rd = 1'b0; m.m2r = 1'b0;
    step();
  endtask

  task automatic t_wb(input logic rd, input logic m2r, input logic [31:0] ret);
    e = '0; m = '1;
    e.st = 3'd4; e.rw = 1'b1; e.rd = rd; e.m2r = m2r; e.ret = ret;
    m.alu = '0; m.sa = '0; m.sb = '0; m.ps = '0;
    step();
  endtask

  task automatic t_halt(input logic [31:0] ret);
    e = '0; m = '1;
    e.st = 3'd5; e.hlt = 1'b1; e.ret = ret;
    m.alu = '0; m.sa = '0; m.sb = '0; m.ps = '0; m.rd = 1'b0; m.m2r = 1'b0;
    step();
  endtask

  // Cycle with rst_n held low: every enable, select and code forced to zero.
  task automatic t_rst(input logic [2:0] st, input logic [31:0] ret);
    e = '0; m = '1;
    e.st = st; e.ret = ret;
    m.hlt = 1'b0;
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(6'h00, 6'h00, 1'b0);
    @(posedge clk); #1;
    tag = "reset";    t_rst(3'd0, 0); t_rst(3'd0, 0);
    rst_n = 1'b1;

    tag = "sub";      set_in(6'h00, 6'h22, 1'b0);
    t_fetch(0); t_decode(0, 0, 0); t_exec(4'h1, 2'b01, 2'b00, 0, 0, 0); t_wb(1, 0, 0);
    tag = "lw";       set_in(6'h23, 6'h00, 1'b0);
    t_fetch(1); t_decode(0, 0, 1); t_exec(4'h0, 2'b01, 2'b10, 0, 0, 1);
    t_mem(1, 0, 1); t_wb(0, 1, 1);
    tag = "sw";       set_in(6'h2B, 6'h00, 1'b0);
    t_fetch(2); t_decode(0, 0, 2); t_exec(4'h0, 2'b01, 2'b10, 0, 0, 2); t_mem(0, 1, 2);
    tag = "beq_z1";   set_in(6'h04, 6'h00, 1'b1);
    t_fetch(3); t_decode(0, 0, 3); t_exec(4'h1, 2'b01, 2'b00, 1, 1, 3);
    tag = "bne_z1";   set_in(6'h05, 6'h00, 1'b1);
    t_fetch(4); t_decode(0, 0, 4); t_exec(4'h1, 2'b01, 2'b00, 0, 1, 4);
    tag = "beq_z0";   set_in(6'h04, 6'h00, 1'b0);
    t_fetch(5); t_decode(0, 0, 5); t_exec(4'h1, 2'b01, 2'b00, 0, 1, 5);
    tag = "bne_z0";   set_in(6'h05, 6'h00, 1'b0);
    t_fetch(6); t_decode(0, 0, 6); t_exec(4'h1, 2'b01, 2'b00, 1, 1, 6);
    tag = "ori";      set_in(6'h0D, 6'h00, 1'b0);
    t_fetch(7); t_decode(0, 0, 7); t_exec(4'h3, 2'b01, 2'b10, 0, 0, 7); t_wb(0, 0, 7);
    tag = "sll";      set_in(6'h00, 6'h00, 1'b0);
    t_fetch(8); t_decode(0, 0, 8); t_exec(4'h2, 2'b10, 2'b00, 0, 0, 8); t_wb(1, 0, 8);
    tag = "slt";      set_in(6'h00, 6'h2A, 1'b0);
    t_fetch(9); t_decode(0, 0, 9); t_exec(4'h6, 2'b01, 2'b00, 0, 0, 9); t_wb(1, 0, 9);
    tag = "j";        set_in(6'h02, 6'h00, 1'b0);
    t_fetch(10); t_decode(0, 1, 10);
    tag = "ill_funct"; set_in(6'h00, 6'h3F, 1'b0);
    t_fetch(11); t_decode(1, 0, 11);
    tag = "ill_op";   set_in(6'h10, 6'h00, 1'b0);
    t_fetch(11); t_decode(1, 0, 11);
    tag = "halt";     set_in(6'h3F, 6'h00, 1'b0);
    t_fetch(11); t_decode(0, 0, 11);
    repeat (10) t_halt(11);
    tag = "rst_halt"; rst_n = 1'b0; t_rst(3'd5, 11);
    rst_n = 1'b1;
    tag = "j_after";  set_in(6'h02, 6'h00, 1'b0);
    t_fetch(0); t_decode(0, 1, 0);
    tag = "rst_mem";  set_in(6'h2B, 6'h00, 1'b0);
    t_fetch(1); t_decode(0, 0, 1); t_exec(4'h0, 2'b01, 2'b10, 0, 0, 1);
    rst_n = 1'b0; t_rst(3'd3, 1);
    rst_n = 1'b1;
    tag = "after_rst"; t_fetch(0);

    @(negedge clk); #1;
    if (q_e.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending required 0", q_e.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "timeout");
  end

endmodule
